// File: rtl/wager_bank.sv
// Bankroll keeper for the baccarat game: locks a wager/bet per round,
// settles the outcome into the balance and flags game over at zero.
module wager_bank #(
  parameter logic [7:0] INIT_BALANCE = 8'd100,
  parameter int         TIE_MULT     = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [7:0] wager_in,
  input  logic [1:0] bet_in,
  input  logic       load_wager,
  input  logic [1:0] result,
  input  logic       result_valid,
  output logic [7:0] balance_out,
  output logic       betting,
  output logic [7:0] wager_out,
  output logic [1:0] bet_out,
  output logic       reject,
  output logic       settle_done,
  output logic       broke
);

  typedef enum logic [1:0] {BET, PLAY, SETTLE, BROKE} state_t;

  localparam logic [11:0] TIE_MULT_W = 12'(TIE_MULT);

  state_t     state_reg, state_next;
  logic [7:0] balance_reg;
  logic [7:0] wager_reg;
  logic [1:0] bet_reg;
  logic [1:0] result_reg;
  logic       reject_reg;
  logic       settle_done_reg;

  logic       wager_ok;
  logic       result_ok;
  logic [11:0] bal_ext, wager_ext, sum12;
  logic [7:0] balance_settled;

  assign wager_ok  = (wager_in != 8'd0) && (wager_in <= balance_reg) && (bet_in != 2'b00);
  assign result_ok = result_valid && (result != 2'b00);
  assign bal_ext   = {4'b0000, balance_reg};
  assign wager_ext = {4'b0000, wager_reg};

  // Settlement value; sums use 12-bit intermediates and clamp at 255.
  always_comb begin
    sum12           = bal_ext;
    balance_settled = balance_reg;
    if ((result_reg == bet_reg) && (result_reg != 2'b11)) begin
      sum12 = bal_ext + wager_ext;
    end else if ((result_reg == 2'b11) && (bet_reg == 2'b11)) begin
      sum12 = bal_ext + wager_ext * TIE_MULT_W;
    end else if (result_reg == 2'b11) begin
      sum12 = bal_ext;
    end else begin
      sum12 = bal_ext - wager_ext;
    end
    if (sum12 > 12'd255) begin
      balance_settled = 8'hFF;
    end else begin
      balance_settled = sum12[7:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BET:     if (load_wager && wager_ok) state_next = PLAY;
      PLAY:    if (result_ok) state_next = SETTLE;
      SETTLE:  state_next = (balance_settled == 8'd0) ? BROKE : BET;
      default: state_next = BROKE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_reg       <= BET;
      balance_reg     <= INIT_BALANCE;
      wager_reg       <= 8'd0;
      bet_reg         <= 2'b00;
      result_reg      <= 2'b00;
      reject_reg      <= 1'b0;
      settle_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      reject_reg      <= 1'b0;
      settle_done_reg <= 1'b0;
      case (state_reg)
        BET: begin
          if (load_wager) begin
            if (wager_ok) begin
              wager_reg <= wager_in;
              bet_reg   <= bet_in;
            end else begin
              reject_reg <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (result_ok) result_reg <= result;
        end
        SETTLE: begin
          balance_reg     <= balance_settled;
          wager_reg       <= 8'd0;
          bet_reg         <= 2'b00;
          result_reg      <= 2'b00;
          settle_done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign balance_out = balance_reg;
  assign wager_out   = wager_reg;
  assign bet_out     = bet_reg;
  assign reject      = reject_reg;
  assign settle_done = settle_done_reg;
  assign betting     = (state_reg == BET);
  assign broke       = (state_reg == BROKE);

endmodule

// File: tb/tb_wager_bank.sv
// Directed self-checking bench for wager_bank.
module tb_wager_bank;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic [7:0] wager_in = 8'd0;
  logic [1:0] bet_in = 2'b00;
  logic       load_wager = 1'b0;
  logic [1:0] result = 2'b00;
  logic       result_valid = 1'b0;
  logic [7:0] balance_out;
  logic       betting;
  logic [7:0] wager_out;
  logic [1:0] bet_out;
  logic       reject;
  logic       settle_done;
  logic       broke;

  int checks = 0;
  int passed = 0;

  wager_bank dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .wager_in    (wager_in),
    .bet_in      (bet_in),
    .load_wager  (load_wager),
    .result      (result),
    .result_valid(result_valid),
    .balance_out (balance_out),
    .betting     (betting),
    .wager_out   (wager_out),
    .bet_out     (bet_out),
    .reject      (reject),
    .settle_done (settle_done),
    .broke       (broke)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] w, input logic [1:0] b);
    wager_in = w;
    bet_in = b;
    load_wager = 1'b1;
    tick();
    load_wager = 1'b0;
  endtask

  task automatic do_result(input logic [1:0] r);
    result = r;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    result = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    $display("txn reset");
    checks++; if (balance_out !== 8'd100) $display("FAIL reset_bal: got %0d want 100", balance_out); else passed++;
    checks++; if (betting !== 1'b1) $display("FAIL reset_betting: got %0b want 1", betting); else passed++;
    checks++; if (wager_out !== 8'd0 || bet_out !== 2'b00) $display("FAIL reset_wager: got %0d/%0d want 0/0", wager_out, bet_out); else passed++;
    checks++; if ({reject, settle_done, broke} !== 3'b000) $display("FAIL reset_flags: got %03b want 000", {reject, settle_done, broke}); else passed++;
  endtask

  task automatic test_win();
    do_reset();
    do_load(8'd20, 2'b01);
    $display("txn load 20/01 -> wager_out %0d betting %0b", wager_out, betting);
    checks++; if (betting !== 1'b0) $display("FAIL win_betting_low: got %0b want 0", betting); else passed++;
    checks++; if (wager_out !== 8'd20 || bet_out !== 2'b01) $display("FAIL win_lock: got %0d/%0d want 20/1", wager_out, bet_out); else passed++;
    // In PLAY, result 00 and a new load_wager are both ignored.
    do_result(2'b00);
    do_load(8'd5, 2'b10);
    checks++; if (wager_out !== 8'd20 || bet_out !== 2'b01 || betting !== 1'b0) $display("FAIL play_ignore: got %0d/%0d/%0b want 20/1/0", wager_out, bet_out, betting); else passed++;
    do_result(2'b01);
    checks++; if (balance_out !== 8'd100 || settle_done !== 1'b0) $display("FAIL win_latency: got %0d/%0b want 100/0", balance_out, settle_done); else passed++;
    tick();
    $display("txn result 01 -> balance %0d settle_done %0b", balance_out, settle_done);
    checks++; if (balance_out !== 8'd120) $display("FAIL win_bal: got %0d want 120", balance_out); else passed++;
    checks++; if (settle_done !== 1'b1 || betting !== 1'b1) $display("FAIL win_done: got %0b/%0b want 1/1", settle_done, betting); else passed++;
    checks++; if (wager_out !== 8'd0 || bet_out !== 2'b00) $display("FAIL win_clear: got %0d/%0d want 0/0", wager_out, bet_out); else passed++;
    tick();
    checks++; if (settle_done !== 1'b0) $display("FAIL win_done_pulse: got %0b want 0", settle_done); else passed++;
  endtask

  task automatic test_loss_push();
    do_reset();
    do_load(8'd30, 2'b10);
    do_result(2'b01);
    tick();
    $display("txn 30/10 result 01 -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd70) $display("FAIL loss_bal: got %0d want 70", balance_out); else passed++;
    do_load(8'd10, 2'b01);
    do_result(2'b11);
    tick();
    $display("txn 10/01 result 11 -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd70 || settle_done !== 1'b1) $display("FAIL push_bal: got %0d/%0b want 70/1", balance_out, settle_done); else passed++;
    tick();
    do_load(8'd5, 2'b10);
    do_result(2'b10);
    tick();
    $display("txn 5/10 result 10 -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd75) $display("FAIL dealer_win_bal: got %0d want 75", balance_out); else passed++;
  endtask

  task automatic test_reject();
    do_reset();
    do_load(8'd200, 2'b01);
    $display("txn load 200/01 -> reject %0b", reject);
    checks++; if (reject !== 1'b1 || betting !== 1'b1 || wager_out !== 8'd0) $display("FAIL rej_over: got %0b/%0b/%0d want 1/1/0", reject, betting, wager_out); else passed++;
    tick();
    checks++; if (reject !== 1'b0) $display("FAIL rej_pulse: got %0b want 0", reject); else passed++;
    do_load(8'd0, 2'b01);
    checks++; if (reject !== 1'b1 || betting !== 1'b1) $display("FAIL rej_zero: got %0b/%0b want 1/1", reject, betting); else passed++;
    do_load(8'd50, 2'b00);
    $display("txn load 50/00 -> reject %0b", reject);
    checks++; if (reject !== 1'b1 || betting !== 1'b1) $display("FAIL rej_nobet: got %0b/%0b want 1/1", reject, betting); else passed++;
    do_load(8'd101, 2'b10);
    checks++; if (reject !== 1'b1 || wager_out !== 8'd0) $display("FAIL rej_101: got %0b/%0d want 1/0", reject, wager_out); else passed++;
  endtask

  task automatic test_tie_saturate();
    do_reset();
    do_load(8'd40, 2'b11);
    do_result(2'b11);
    tick();
    $display("txn 40/11 result 11 -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd255) $display("FAIL tie_sat: got %0d want 255", balance_out); else passed++;
    do_load(8'd1, 2'b11);
    do_result(2'b11);
    tick();
    $display("txn 1/11 result 11 -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd255 || settle_done !== 1'b1) $display("FAIL tie_sat2: got %0d/%0b want 255/1", balance_out, settle_done); else passed++;
    do_reset();
    do_load(8'd10, 2'b11);
    do_result(2'b11);
    tick();
    checks++; if (balance_out !== 8'd180) $display("FAIL tie_win: got %0d want 180", balance_out); else passed++;
    do_load(8'd20, 2'b11);
    do_result(2'b10);
    tick();
    checks++; if (balance_out !== 8'd160) $display("FAIL tie_loss: got %0d want 160", balance_out); else passed++;
  endtask

  task automatic test_broke();
    do_reset();
    do_load(8'd100, 2'b01);
    checks++; if (wager_out !== 8'd100 || reject !== 1'b0) $display("FAIL broke_lock: got %0d/%0b want 100/0", wager_out, reject); else passed++;
    do_result(2'b10);
    tick();
    $display("txn 100/01 result 10 -> balance %0d broke %0b", balance_out, broke);
    checks++; if (balance_out !== 8'd0 || broke !== 1'b1 || betting !== 1'b0) $display("FAIL broke_state: got %0d/%0b/%0b want 0/1/0", balance_out, broke, betting); else passed++;
    do_load(8'd10, 2'b01);
    do_result(2'b01);
    tick();
    tick();
    checks++; if (balance_out !== 8'd0 || broke !== 1'b1 || wager_out !== 8'd0 || reject !== 1'b0 || settle_done !== 1'b0) $display("FAIL broke_absorb: got %0d/%0b/%0d/%0b/%0b want 0/1/0/0/0", balance_out, broke, wager_out, reject, settle_done); else passed++;
    do_reset();
    $display("txn reset from broke -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd100 || betting !== 1'b1 || broke !== 1'b0) $display("FAIL broke_exit: got %0d/%0b/%0b want 100/1/0", balance_out, betting, broke); else passed++;
  endtask

  task automatic test_reset_mid_round();
    do_reset();
    do_load(8'd50, 2'b01);
    do_reset();
    $display("txn reset in PLAY -> balance %0d wager_out %0d", balance_out, wager_out);
    checks++; if (balance_out !== 8'd100 || wager_out !== 8'd0 || betting !== 1'b1) $display("FAIL mid_reset: got %0d/%0d/%0b want 100/0/1", balance_out, wager_out, betting); else passed++;
    do_result(2'b01);
    tick();
    checks++; if (balance_out !== 8'd100 || settle_done !== 1'b0 || betting !== 1'b1) $display("FAIL mid_stale_result: got %0d/%0b/%0b want 100/0/1", balance_out, settle_done, betting); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    // load_wager and result_valid together in BET: only the load matters.
    wager_in = 8'd10;
    bet_in = 2'b10;
    load_wager = 1'b1;
    result = 2'b01;
    result_valid = 1'b1;
    tick();
    load_wager = 1'b0;
    result_valid = 1'b0;
    checks++; if (wager_out !== 8'd10 || betting !== 1'b0) $display("FAIL b2b_lock: got %0d/%0b want 10/0", wager_out, betting); else passed++;
    // Same pair in PLAY: only the result matters.
    wager_in = 8'd99;
    load_wager = 1'b1;
    result = 2'b10;
    result_valid = 1'b1;
    tick();
    load_wager = 1'b0;
    result_valid = 1'b0;
    tick();
    $display("txn simultaneous strobes -> balance %0d", balance_out);
    checks++; if (balance_out !== 8'd110 || settle_done !== 1'b1) $display("FAIL b2b_settle: got %0d/%0b want 110/1", balance_out, settle_done); else passed++;
  endtask

  initial begin
    test_reset();
    test_win();
    test_loss_push();
    test_reject();
    test_tie_saturate();
    test_broke();
    test_reset_mid_round();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wager_bank.md
Name: wager_bank

Overview:
- Owns the player's bankroll for the baccarat game.
- Validates and locks the wager and bet at the start of each round, then waits for the round result from the game state machine.
- Settles payout or loss into the balance and reports the balance and betting status back to the top level.
- Directly downstream of the statemachine's result output; upstream of the LEDR balance display and of the betting gate.

Parameters:
- INIT_BALANCE, 8'd100, balance loaded on reset.
- TIE_MULT, 8, payout multiplier for a winning tie bet.

Ports:
- slow_clock, input, 1: single clock; all state changes on its rising edge.
- resetb, input, 1: synchronous, active-high reset (1 = reset; name kept for codebase consistency).
- wager_in, input, 8: requested wager, unsigned.
- bet_in, input, 2: bet choice. 00 none, 01 player, 10 dealer, 11 tie.
- load_wager, input, 1: one-cycle request to lock wager_in/bet_in.
- result, input, 2: round outcome. 00 none, 01 player wins, 10 dealer wins, 11 tie.
- result_valid, input, 1: one-cycle strobe qualifying result.
- balance_out, output, 8: current bankroll.
- betting, output, 1: high while a new wager is accepted.
- wager_out, output, 8: locked wager for the current round.
- bet_out, output, 2: locked bet.
- reject, output, 1: one-cycle pulse when load_wager is refused.
- settle_done, output, 1: one-cycle pulse after the balance is updated.
- broke, output, 1: high when the balance has reached 0; game over.

Behaviour:
- Reset, sampled synchronously:
  - state = BET, balance_out = INIT_BALANCE, wager_out = 0, bet_out = 00.
  - reject = 0, settle_done = 0, broke = 0, betting = 1.
  - Reset mid-round discards the locked wager; no partial settlement.
- States: BET, PLAY, SETTLE, BROKE. betting = 1 only in BET; broke = 1 only in BROKE.
- BET:
  - load_wager is accepted when wager_in != 0, wager_in <= balance_out and bet_in != 00.
  - On accept: wager_out and bet_out latch on the same edge; next state is PLAY.
  - Otherwise: reject = 1 on the next cycle and state stays BET.
  - Balance is unchanged until settlement.
- PLAY:
  - Waits for result_valid with result != 00, then goes to SETTLE on the next edge.
  - result_valid with result 00 is ignored.
  - load_wager is ignored.
- SETTLE, one cycle; balance is written on its closing edge:
  - Win (bet_out == result, with result 01 or 10): balance + wager_out.
  - Tie bet wins (bet 11, result 11): balance + TIE_MULT*wager_out.
  - Push (result 11, bet 01 or 10): no change.
  - Loss (all other cases): balance - wager_out. This cannot underflow, since wager <= balance at lock time.
- Arithmetic: intermediates are 12 bits wide; additions saturate at 255.
- settle_done pulses high for the cycle after SETTLE. wager_out and bet_out clear to 0 on the same edge.
- Next state after SETTLE: BROKE if the new balance == 0, else BET.
- BROKE: absorbing state; all inputs are ignored. Only resetb exits it.
- Latency: result_valid to updated balance_out is 2 edges; settle_done is asserted in the cycle balance_out first shows the new value.
- Simultaneous load_wager and result_valid: interpreted only per the current state (BET takes load_wager, PLAY takes result_valid).

Test Plan:
- Reset, then load_wager with wager 20 and bet 01 → betting drops, wager_out = 20. Then result 01 → balance 120, settle_done pulses once, betting = 1.
- Wager 30, bet 10, result 01 → balance 70. Wager 10, bet 01, result 11 (push) → balance 70.
- Wager 200 with balance 100 → reject pulse, stays in BET. Wager 0 or bet 00 → reject.
- Wager 40, bet 11, result 11 → 100 + 320 saturates to 255. A further tie win with wager 1 → stays at 255.
- Wager 100, bet 01, result 10 → balance 0, broke = 1. Later load_wager and result_valid produce no change. resetb → balance 100, BET.
- resetb asserted in PLAY with wager 50 locked → balance 100, wager_out 0, state BET. A later result_valid has no effect until a new wager is locked.
